// File: rtl/psum_drain_fifo.sv
// Result drain for the bottom of a PE-array column: tracks FPU results in flight with a
// delay line, captures them as they emerge, and buffers them for a ready/valid consumer.
module psum_drain_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int PIPE_LAT   = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rest,
    input  logic                  i_issue,
    input  logic [DATA_WIDTH-1:0] i_psum,
    output logic                  o_stall,
    output logic [DATA_WIDTH-1:0] o_psum_data,
    output logic                  o_psum_valid,
    input  logic                  i_psum_ready,
    output logic [ADDR_W:0]       o_count,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_overflow
);
    localparam int IF_W  = $clog2(PIPE_LAT + 1);
    localparam int SUM_W = ((IF_W > ADDR_W + 1) ? IF_W : ADDR_W + 1) + 1;

    logic [PIPE_LAT-1:0]   dly_q, dly_d;
    logic [IF_W-1:0]       in_flight_q, in_flight_d;
    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]       count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  cap;
    logic                  pop;
    logic                  push;
    logic [SUM_W-1:0]      occupancy;

    always_comb begin
        cap          = dly_q[PIPE_LAT-1];
        o_empty      = (count_q == '0);
        o_full       = (count_q == (ADDR_W+1)'(DEPTH));
        pop          = !o_empty && i_psum_ready;
        // A full FIFO can still accept a capture when the head leaves in the same cycle.
        push         = cap && (!o_full || pop);

        dly_d        = PIPE_LAT'({dly_q, i_issue});
        in_flight_d  = in_flight_q + IF_W'(i_issue) - IF_W'(cap);
        count_d      = count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
        wr_ptr_d     = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        overflow_d   = overflow_q || (cap && o_full && !pop);

        // Every issued operation already owns a slot, so stall on reserved space, not stored.
        occupancy    = SUM_W'(in_flight_q) + SUM_W'(count_q);
        o_stall      = (occupancy >= SUM_W'(DEPTH));

        o_psum_valid = !o_empty;
        o_psum_data  = o_empty ? '0 : mem_q[rd_ptr_q];
        o_count      = count_q;
        o_overflow   = overflow_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rest) begin
            dly_q       <= '0;
            in_flight_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            dly_q       <= dly_d;
            in_flight_q <= in_flight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_psum;
        end
    end
endmodule

// File: doc/psum_drain_fifo.md
Name: psum_drain_fifo

Overview:
- Sits below the bottom MPE row of a PE-array column and consumes the column's `psum_t_down` stream.
- The FPU mul/add chain has a fixed pipeline latency and no valid signal. This block therefore tracks issued operations with a delay line, captures each result when it emerges, and buffers it in a FIFO.
- Results are handed to the writeback side over a ready/valid interface.
- It drives a credit-based stall back to the operand feeder so that no in-flight result can be lost.

Parameters:
- DATA_WIDTH, 32, width of one FP32 partial sum.
- PIPE_LAT, 8, cycles from `i_issue` to the matching result on `i_psum` (mul + add latency); legal range 1..32.
- DEPTH, 16, FIFO entries; must be a power of two, at least 2.
- ADDR_W, 4, log2(DEPTH).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rest  input  1  synchronous active-high reset.
- i_issue  input  1  feeder launched one operand pair into the bottom PE this cycle.
- i_psum  input  DATA_WIDTH  `psum_t_down` of the bottom PE.
- o_stall  output  1  feeder must not assert `i_issue` while high.
- o_psum_data  output  DATA_WIDTH  head-of-FIFO partial sum.
- o_psum_valid  output  1  head entry is valid.
- i_psum_ready  input  1  consumer accepts the head entry.
- o_count  output  ADDR_W+1  entries currently stored (0..DEPTH).
- o_empty  output  1  count == 0.
- o_full  output  1  count == DEPTH.
- o_overflow  output  1  sticky flag: a result was dropped.

Behaviour:
- **Reset:**
  - Sampled on the rising edge of `i_clk` while `i_rest` = 1.
  - Clears the delay line, read/write pointers, count, in-flight counter and `o_overflow`.
  - After reset: `o_psum_valid` = 0, `o_psum_data` = 0, `o_count` = 0, `o_empty` = 1, `o_full` = 0, `o_stall` = 0.
  - Reset mid-operation discards all stored and in-flight results. FIFO memory contents need no reset.
- **Delay line:**
  - PIPE_LAT-bit shift register; bit 0 loads `i_issue` each cycle.
  - `cap` = bit PIPE_LAT-1. `i_issue` at cycle t gives `cap` = 1 at cycle t+PIPE_LAT.
  - When `cap` = 1, `i_psum` is sampled in that cycle and is the push data.
- **In-flight counter** (0..PIPE_LAT): +1 on `i_issue`, -1 on `cap`, unchanged when both occur.
- **Stall:**
  - `o_stall` = 1 when (in_flight + count) >= DEPTH. Registered-free, combinational from state.
  - `i_issue` while `o_stall` = 1 is a protocol violation but is still tracked.
- **Push:**
  - Occurs when `cap` = 1 and (not full, or a pop happens in the same cycle).
  - Writes `mem[wr_ptr]`; `wr_ptr` increments modulo DEPTH (natural wrap at ADDR_W bits).
- **Drop:** `cap` = 1 with FIFO full and no same-cycle pop drops the data and sets `o_overflow` = 1 (sticky until reset). Count is unchanged.
- **Read (first-word fall-through):**
  - `o_psum_valid` = !empty.
  - `o_psum_data` = `mem[rd_ptr]` when valid, 0 when empty.
  - Pop occurs when `o_psum_valid` & `i_psum_ready`; `rd_ptr` increments modulo DEPTH.
  - `i_psum_ready` while empty has no effect.
- **Simultaneous push and pop:** count unchanged, both pointers advance. This is legal when full: the freed slot is reused.
- **Latency:** a result captured at cycle c appears on `o_psum_data` with `o_psum_valid` = 1 at cycle c+1 if the FIFO was empty.
- **Ordering:** strict FIFO in issue order.
- **Count update:** `o_count` = count after push/pop that edge. `o_full`/`o_empty` are derived from `o_count`.

Test Plan:
- **Reset and single result:** assert `i_rest` 2 cycles, then `i_issue` at cycle 0, drive `i_psum` = 0x3F800000 at cycle 8, hold `i_psum_ready` = 0.
  - Required: valid = 1 and data = 0x3F800000 from cycle 9.
  - Required: count = 1, `o_empty` = 0.
  - Required after ready = 1 for one cycle: count = 0 and data = 0.
- **Burst with backpressure and wrap:** issue 16 back-to-back with `i_psum` = k at cycle 8+k, ready = 0.
  - Required: `o_stall` = 1 from the cycle in_flight + count reaches 16.
  - Required: `o_full` = 1 after the last capture.
  - Then ready = 1 continuously: outputs 0..15 in order. Repeat once more to exercise pointer wrap.
- **Full with simultaneous push/pop:** FIFO full, `cap` = 1 and ready = 1 in the same cycle.
  - Required: count stays 16, new value lands at the tail, `o_overflow` stays 0.
- **Overflow:** FIFO full, ready = 0, force `i_issue` despite stall.
  - Required: after 8 cycles `o_overflow` = 1 and count = 16; stored data is unchanged.
  - Required: `o_overflow` remains 1 until `i_rest`.
- **Reset mid-flight:** 5 issues outstanding and 3 stored, then pulse `i_rest`.
  - Required: count = 0, valid = 0, `o_stall` = 0.
  - Required: no capture occurs at the old cap times, even with nonzero `i_psum`.
- **Random:** random `i_issue` (respecting `o_stall`), random ready, 10k cycles.
  - Required: scoreboard order matches, `o_overflow` never sets, and count never exceeds DEPTH.
